machine_trace: RTL
==================

# machine_trace

Trace-capture stage downstream of the 3-bit JK sequence machine. It watches the machine's state vector `S` and flag `F` every cycle and records each state transition as a 7-bit event into a small FIFO. A host drains the FIFO through a request/valid read port. Capture is armed by command, triggers on the first `F` assertion, stores a fixed number of post-trigger events, then freezes for readout.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `POST`, 4: events stored after the trigger event before freezing; range 0..DEPTH-1.
- `CNT_W`, 8: width of the `F` rising-edge counter.

- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET` input 1: synchronous, active-high; clears all state.
- `S` input 3: machine state vector {A,B,C}.
- `F` input 1: machine output flag.
- `arm` input 1: one-cycle command to start a capture.
- `rd_req` input 1: read request; honoured only when `empty`=0.
- `rd_data` output 7: event {F, prev_S[2:0], S[2:0]}.
- `rd_valid` output 1: `rd_data` is valid this cycle.
- `empty` output 1: FIFO holds no entries.
- `full` output 1: FIFO holds DEPTH entries.
- `overflow` output 1: sticky; an event was dropped because the FIFO was full.
- `f_count` output CNT_W: saturating count of `F` rising edges since the last arm.
- `mode` output 2: FSM state, encoded IDLE=0, ARMED=1, POSTTRIG=2, DONE=3.

## Operation
- `prev_S` register: loads `S` every cycle; reset value 3'b000.
- Event: the cycle where `S != prev_S`. Its entry is {F, prev_S, S}.
- FSM:
  - IDLE: no writes. `arm` -> ARMED.
  - ARMED: write every event. An event with `F`=1 is the trigger: it is written, then the FSM goes to POSTTRIG, or straight to DONE if POST=0. The post-trigger counter loads 0.
  - POSTTRIG: write every event and increment the post counter. When the POST-th event is written -> DONE.
  - DONE: no writes. `arm` -> ARMED.
- `arm` in ARMED or POSTTRIG restarts the capture (-> ARMED).
- Any `arm` flushes the FIFO pointers and clears `overflow`, `f_count` and the post counter in the same edge. No event is written in the arm cycle.
- Write with FIFO full (pre-edge) and no read that cycle: the event is dropped and `overflow` is set. The drop still counts toward POST, so the FSM still reaches DONE.
- Write and read in the same cycle while full: both occur, occupancy is unchanged, and no overflow is flagged.
- `rd_req` while `empty`=1 is ignored: `rd_valid` stays 0 and pointers do not move.
- `f_count`: increments when `F`=1 and `F` was 0 the previous cycle, in ARMED or POSTTRIG only. It saturates at 2^CNT_W-1 and does not wrap.
- Pointers are log2(DEPTH)+1 bits; wrap-around is natural modulo.
  - `full` = MSBs differ and the index bits are equal.
  - `empty` = pointers are equal.

## Timing
- Reset values:
  - `rd_data` = 0, `rd_valid` = 0, `overflow` = 0, `f_count` = 0.
  - `empty` = 1, `full` = 0, `mode` = IDLE.
  - `prev_S` = 0.
- `RESET` mid-capture discards all FIFO contents and returns to IDLE on that edge. `RESET` dominates `arm`.
- Read latency: 1 cycle. `rd_req` accepted in cycle n gives `rd_valid`=1 and `rd_data` in cycle n+1. `rd_valid` is a single-cycle pulse per accepted request. Back-to-back requests give one entry per cycle.
- Write latency: an event in cycle n updates `empty` and `full` at n+1, and is readable by an `rd_req` in cycle n+1.
- `mode` changes on the edge that ends the cycle in which the transition condition is true.

## Structure
- Shared package `machine_trace_pkg`:
  - mode encoding constants (IDLE, ARMED, POSTTRIG, DONE);
  - event width constant (7);
  - event field offsets (F bit 6, prev_S 5:3, S 2:0).
- One sub-module, `trace_fifo`: a synchronous single-clock FIFO (DEPTH × 7) with write-enable, read-request, `empty`/`full` and 1-cycle registered read data.
- Event detection, the FSM, the post counter, `f_count` and `overflow` live in `machine_trace`.

## Test plan
- Reset, then drive S 0->1->2 with no `arm` -> `empty` stays 1 and `mode`=0.
- `arm`, drive S 0->1->5->7 with F=1 only at S=7, POST=0:
  - `mode` goes 1 then 3;
  - three reads return 7'h01, 7'h0D, 7'h6F;
  - `f_count`=1.
- `arm`, with DEPTH=8, drive 10 transitions with F=0 and no reads -> `full`=1, `overflow`=1, and the first 8 events read back in order.
- Full FIFO with `rd_req` and an event in the same cycle -> `full` stays 1, `overflow` stays 0, and the first read returns the oldest entry.
- `RESET` asserted in POSTTRIG with 3 entries stored -> the next cycle shows `empty`=1, `mode`=0, `f_count`=0.
- CNT_W=2, 5 `F` pulses while ARMED with POST large enough that the FSM does not reach DONE -> `f_count` saturates at 3; a following `arm` clears it to 0.

Source files
------------

// File: rtl/machine_trace_pkg.sv
// Shared definitions for the JK-machine trace-capture stage: capture mode
// encoding, the event word layout and a helper that packs an event.
package machine_trace_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE     = 2'd0,
    MODE_ARMED    = 2'd1,
    MODE_POSTTRIG = 2'd2,
    MODE_DONE     = 2'd3
  } mode_t;

  localparam int EVT_W       = 7;
  localparam int EVT_F_BIT   = 6;
  localparam int EVT_PREV_HI = 5;
  localparam int EVT_PREV_LO = 3;
  localparam int EVT_S_HI    = 2;
  localparam int EVT_S_LO    = 0;

  // Event word: {F, prev_S, S}.
  function automatic logic [EVT_W-1:0] make_event(input logic       f,
                                                  input logic [2:0] prev_s,
                                                  input logic [2:0] s);
    logic [EVT_W-1:0] e;
    e = '0;
    e[EVT_F_BIT]               = f;
    e[EVT_PREV_HI:EVT_PREV_LO] = prev_s;
    e[EVT_S_HI:EVT_S_LO]       = s;
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Single-clock FIFO holding captured trace events.
// Read port handshake: rd_req is honoured only when empty=0 (and no flush);
// an accepted request in cycle n yields rd_valid=1 with rd_data in cycle n+1,
// one entry per accepted request, back-to-back requests stream one per cycle.
// A write while full is only accepted if a read is accepted in the same cycle.
module trace_fifo
  import machine_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = EVT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_req,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         rd_fire;
  logic         wr_fire;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_fire = rd_req && !empty && !flush;
  assign wr_fire = wr_en && (!full || rd_fire) && !flush;

  // Pointer update; flush rewinds both pointers so the FIFO reads as empty.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Registered read data and its one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: rtl/machine_trace.sv
// Trace capture for the 3-bit JK sequence machine: detects state changes,
// arms/triggers/freezes capture with a small FSM, counts F rising edges and
// flags dropped events. Events are buffered in trace_fifo for host readout.
module machine_trace
  import machine_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int POST  = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [2:0]       S,
  input  logic             F,
  input  logic             arm,
  input  logic             rd_req,
  output logic [EVT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic [CNT_W-1:0] f_count,
  output logic [1:0]       mode
);

  localparam int            PW     = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] POST_V = PW'(POST);

  mode_t         state;
  mode_t         state_nxt;
  logic [2:0]    prev_s;
  logic          prev_f;
  logic [PW-1:0] post_cnt;
  logic [PW-1:0] post_cnt_inc;
  logic          evt;
  logic          capturing;
  logic          wr_en;
  logic          trigger;
  logic          post_step;
  logic          f_rise;

  assign evt          = (S != prev_s);
  assign capturing    = (state == MODE_ARMED) || (state == MODE_POSTTRIG);
  assign wr_en        = evt && capturing && !arm;
  assign trigger      = wr_en && F && (state == MODE_ARMED);
  assign post_step    = wr_en && (state == MODE_POSTTRIG);
  assign post_cnt_inc = post_cnt + PW'(1);
  assign f_rise       = F && !prev_f;
  assign mode         = state;

  // Previous-cycle copies of S and F for event and edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_s <= 3'b000;
      prev_f <= 1'b0;
    end else begin
      prev_s <= S;
      prev_f <= F;
    end
  end

  // Capture FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= MODE_IDLE;
    else       state <= state_nxt;
  end

  // Capture FSM next state; arm always restarts the capture.
  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = MODE_ARMED;
    end else begin
      case (state)
        MODE_ARMED: begin
          if (trigger) begin
            if (POST == 0) state_nxt = MODE_DONE;
            else           state_nxt = MODE_POSTTRIG;
          end
        end
        MODE_POSTTRIG: begin
          if (post_step && (post_cnt_inc == POST_V)) state_nxt = MODE_DONE;
        end
        default: ;
      endcase
    end
  end

  // Post-trigger event counter; dropped events still count.
  always_ff @(posedge CLK) begin
    if (RESET || arm)   post_cnt <= '0;
    else if (trigger)   post_cnt <= '0;
    else if (post_step) post_cnt <= post_cnt_inc;
  end

  // Saturating count of F rising edges while capturing.
  always_ff @(posedge CLK) begin
    if (RESET || arm) begin
      f_count <= '0;
    end else if (capturing && f_rise && (f_count != {CNT_W{1'b1}})) begin
      f_count <= f_count + CNT_W'(1);
    end
  end

  // Sticky drop flag: an event met a full FIFO with no read to make room.
  always_ff @(posedge CLK) begin
    if (RESET || arm)                    overflow <= 1'b0;
    else if (wr_en && full && !rd_req)   overflow <= 1'b1;
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk      (CLK),
    .reset    (RESET),
    .flush    (arm),
    .wr_en    (wr_en),
    .wr_data  (make_event(F, prev_s, S)),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full)
  );

endmodule
